// File: rtl/huff_sched_pkg.sv
// Shared types and defaults for the Huffman encoder frame scheduler.
package huff_sched_pkg;

    localparam int FRAME_LEN_DEF = 256;
    localparam int SYM_W_DEF     = 4;
    localparam int MAX_SYM_DEF   = 9;

    typedef logic [SYM_W_DEF-1:0] sym_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_STREAM,
        ST_WAIT,
        ST_REPORT,
        ST_RECOVER
    } state_t;

endpackage

// File: rtl/huff_rr_arbiter.sv
// Two-way round-robin arbiter; the last-grant record only advances when a frame
// has been fully retired (reported or dropped), not when the grant is issued.
module huff_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_grant_done,
    input  logic i_done_src,
    output logic o_any,
    output logic o_sel
);

    logic r_last;

    // r_last=1 out of reset so src0 wins the first contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last <= 1'b1;
        else if (i_grant_done)
            r_last <= i_done_src;
    end

    assign o_any = i_req0 | i_req1;
    assign o_sel = (i_req0 && i_req1) ? ~r_last : i_req1;

endmodule

// File: rtl/huff_frame_sched.sv
// Collects a frame from one of two sources, streams it into the Huffman encoder
// and reports how long the encoder took, resetting the encoder on timeout.
module huff_frame_sched
    import huff_sched_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int SYM_W     = SYM_W_DEF,
    parameter int MAX_SYM   = MAX_SYM_DEF,
    parameter int TIMEOUT   = 4096,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src0_valid,
    input  logic [SYM_W-1:0] src0_data,
    output logic             src0_ready,
    input  logic             src1_valid,
    input  logic [SYM_W-1:0] src1_data,
    output logic             src1_ready,
    output logic             enc_rst_n,
    output logic             enc_start,
    output logic [SYM_W-1:0] enc_data,
    input  logic             enc_done,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] frame_cycles,
    output logic             frame_src,
    output logic             err_symbol,
    output logic             err_timeout
);

    localparam int               IDX_W     = $clog2(FRAME_LEN);
    localparam logic [SYM_W-1:0] MAX_SYM_V = SYM_W'(MAX_SYM);
    localparam logic [CNT_W-1:0] TOUT_V    = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);

    state_t           r_state;
    logic             r_grant;
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cap;
    logic             r_seen;
    logic             r_done_d;
    logic             r_rec;
    logic [CNT_W-1:0] r_frame_cycles;
    logic             r_frame_src;
    logic [SYM_W-1:0] r_buf [FRAME_LEN];

    logic             w_any;
    logic             w_sel;
    logic             w_load;
    logic             w_in_valid;
    logic [SYM_W-1:0] w_in_data;
    logic             w_hs;
    logic             w_bad;
    logic [SYM_W-1:0] w_wdata;
    logic             w_edge;
    logic             w_run;
    logic             w_tout;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_grant_done;

    huff_rr_arbiter u_arb (
        .clk          (clk),
        .rst          (rst),
        .i_req0       (src0_valid),
        .i_req1       (src1_valid),
        .i_grant_done (w_grant_done),
        .i_done_src   (r_grant),
        .o_any        (w_any),
        .o_sel        (w_sel)
    );

    assign w_load       = (r_state == ST_LOAD);
    assign w_in_valid   = r_grant ? src1_valid : src0_valid;
    assign w_in_data    = r_grant ? src1_data  : src0_data;
    assign w_hs         = w_load && w_in_valid;
    assign w_bad        = (w_in_data > MAX_SYM_V);
    assign w_wdata      = w_bad ? '0 : w_in_data;
    assign w_edge       = enc_done && !r_done_d;
    assign w_run        = (r_state == ST_STREAM) || (r_state == ST_WAIT);
    assign w_tout       = w_run && (r_cnt == TOUT_V);
    assign w_cnt_next   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_grant_done = (r_state == ST_REPORT) || ((r_state == ST_RECOVER) && r_rec);

    assign src0_ready   = w_load && !r_grant;
    assign src1_ready   = w_load && r_grant;
    assign enc_start    = (r_state == ST_START);
    assign enc_data     = (r_state == ST_STREAM) ? r_buf[r_rd_idx] : '0;
    assign busy         = (r_state != ST_IDLE);
    assign result_valid = (r_state == ST_REPORT);
    assign frame_cycles = r_frame_cycles;
    assign frame_src    = r_frame_src;
    assign err_symbol   = w_hs && w_bad;
    assign err_timeout  = w_tout;
    // Encoder is held in reset both by our own reset and by timeout recovery
    assign enc_rst_n    = !rst && (r_state != ST_RECOVER);

    // Plain array with no reset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (w_hs)
            r_buf[r_wr_idx] <= w_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_grant        <= 1'b0;
            r_wr_idx       <= '0;
            r_rd_idx       <= '0;
            r_cnt          <= '0;
            r_cap          <= '0;
            r_seen         <= 1'b0;
            r_done_d       <= 1'b0;
            r_rec          <= 1'b0;
            r_frame_cycles <= '0;
            r_frame_src    <= 1'b0;
        end else begin
            r_done_d <= enc_done;
            case (r_state)
                ST_IDLE: begin
                    r_wr_idx <= '0;
                    if (w_any) begin
                        r_grant <= w_sel;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_hs) begin
                        r_wr_idx <= r_wr_idx + 1'b1;
                        if (r_wr_idx == LAST_IDX) begin
                            r_cnt    <= '0;
                            r_rd_idx <= '0;
                            r_state  <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    r_cnt    <= w_cnt_next;
                    r_rd_idx <= '0;
                    r_seen   <= 1'b0;
                    r_state  <= ST_STREAM;
                end
                ST_STREAM: begin
                    r_cnt    <= w_cnt_next;
                    r_rd_idx <= r_rd_idx + 1'b1;
                    if (w_tout) begin
                        r_rec   <= 1'b0;
                        r_state <= ST_RECOVER;
                    end else begin
                        // An early done edge is remembered and reported once the stream ends
                        if (w_edge && !r_seen) begin
                            r_seen <= 1'b1;
                            r_cap  <= r_cnt;
                        end
                        if (r_rd_idx == LAST_IDX) begin
                            if (r_seen || w_edge) begin
                                r_frame_cycles <= r_seen ? r_cap : r_cnt;
                                r_frame_src    <= r_grant;
                                r_state        <= ST_REPORT;
                            end else begin
                                r_state <= ST_WAIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= w_cnt_next;
                    if (w_tout) begin
                        r_rec   <= 1'b0;
                        r_state <= ST_RECOVER;
                    end else if (w_edge) begin
                        r_frame_cycles <= r_cnt;
                        r_frame_src    <= r_grant;
                        r_state        <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    r_state <= ST_IDLE;
                end
                ST_RECOVER: begin
                    r_rec <= 1'b1;
                    if (r_rec)
                        r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huff_frame_sched.sv
// Self-checking bench for huff_frame_sched: table of frame scenarios, a symbol
// scoreboard filled on handshakes and drained while the encoder is fed.
module tb_huff_frame_sched;
    import huff_sched_pkg::*;

    localparam int FL    = 256;
    localparam int TOUT  = 4096;
    localparam int CW    = 16;
    localparam int MAXS  = 9;
    localparam int LIMIT = TOUT + 4 * FL;

    typedef struct {
        int n0;
        int n1;
        int bad;
        int delay;
        bit exp_res;
        int exp_src;
        bit pat;
    } row_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          src0_valid, src1_valid, src0_ready, src1_ready;
    sym_t          src0_data, src1_data, enc_data;
    logic          enc_rst_n, enc_start, enc_done, busy, result_valid;
    logic [CW-1:0] frame_cycles;
    logic          frame_src, err_symbol, err_timeout;

    int   tests = 0, fails = 0, cyc = 0;
    sym_t src0_q[$], src1_q[$], exp_q[$];
    int   last_hs_cyc = 0, start_cyc = 0, res_cyc = 0, res_fc = 0, res_src = 0, tout_cyc = 0;
    bit   res_seen = 0, tout_seen = 0, start_seen = 0;
    int   rstn_low = 0, rdy0 = 0, rdy1 = 0, esym_cnt = 0, both_bad = 0, stream_left = 0;
    int   enc_delay = 0;
    row_t rows[9];

    huff_frame_sched #(
        .FRAME_LEN (FL),
        .SYM_W     (4),
        .MAX_SYM   (MAXS),
        .TIMEOUT   (TOUT),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src0_valid   (src0_valid),
        .src0_data    (src0_data),
        .src0_ready   (src0_ready),
        .src1_valid   (src1_valid),
        .src1_data    (src1_data),
        .src1_ready   (src1_ready),
        .enc_rst_n    (enc_rst_n),
        .enc_start    (enc_start),
        .enc_data     (enc_data),
        .enc_done     (enc_done),
        .busy         (busy),
        .result_valid (result_valid),
        .frame_cycles (frame_cycles),
        .frame_src    (frame_src),
        .err_symbol   (err_symbol),
        .err_timeout  (err_timeout)
    );

    initial begin
        forever begin
            #5 clk = ~clk;
            if (clk) cyc++;
        end
    end

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input int src, input int bad, input bit pat);
        sym_t f[FL];
        int   p[6] = '{5, 3, 6, 5, 0, 7};
        for (int i = 0; i < FL; i++) f[i] = sym_t'($urandom_range(0, MAXS));
        if (pat) for (int i = 0; i < 6; i++) f[i] = sym_t'(p[i]);
        if (bad >= 0) f[bad] = sym_t'(12);
        for (int i = 0; i < FL; i++) begin
            if (src == 0) src0_q.push_back(f[i]);
            else          src1_q.push_back(f[i]);
        end
    endtask

    // Source 0 model: handshake decided mid-cycle, queue advanced after the edge
    initial begin : drv0
        bit hs;
        src0_valid = 1'b0;
        src0_data  = '0;
        forever begin
            @(negedge clk);
            hs = src0_valid && src0_ready && !rst;
            if (hs) exp_q.push_back((src0_data > sym_t'(MAXS)) ? sym_t'(0) : src0_data);
            @(posedge clk);
            #1;
            if (hs) void'(src0_q.pop_front());
            src0_valid = (src0_q.size() > 0);
            src0_data  = src0_valid ? src0_q[0] : sym_t'(0);
        end
    end

    initial begin : drv1
        bit hs;
        src1_valid = 1'b0;
        src1_data  = '0;
        forever begin
            @(negedge clk);
            hs = src1_valid && src1_ready && !rst;
            if (hs) exp_q.push_back((src1_data > sym_t'(MAXS)) ? sym_t'(0) : src1_data);
            @(posedge clk);
            #1;
            if (hs) void'(src1_q.pop_front());
            src1_valid = (src1_q.size() > 0);
            src1_data  = src1_valid ? src1_q[0] : sym_t'(0);
        end
    end

    // Encoder model: raises done enc_delay cycles after start (0 = never)
    initial begin : enc_model
        int t0;
        bit armed;
        enc_done = 1'b0;
        armed    = 1'b0;
        t0       = 0;
        forever begin
            @(negedge clk);
            if (rst || !enc_rst_n) begin
                enc_done = 1'b0;
                armed    = 1'b0;
            end else begin
                if (armed && cyc == t0 + enc_delay) begin
                    enc_done = 1'b1;
                    armed    = 1'b0;
                end
                if (enc_start) begin
                    enc_done = 1'b0;
                    t0       = cyc;
                    armed    = (enc_delay > 0);
                end
            end
        end
    end

    initial begin : monitor
        bit hs0, hs1, bad_hs;
        int e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stream_left = 0;
                continue;
            end
            if (src0_ready && src1_ready) both_bad++;
            if (src0_ready) rdy0++;
            if (src1_ready) rdy1++;
            if (!enc_rst_n) rstn_low++;
            hs0    = src0_valid && src0_ready;
            hs1    = src1_valid && src1_ready;
            bad_hs = (hs0 && src0_data > sym_t'(MAXS)) || (hs1 && src1_data > sym_t'(MAXS));
            if (hs0 || hs1) last_hs_cyc = cyc;
            if (bad_hs || err_symbol) check("err_symbol", int'(err_symbol), int'(bad_hs));
            if (err_symbol) esym_cnt++;
            if (stream_left > 0) begin
                if (exp_q.size() > 0) e = int'(exp_q.pop_front());
                else                  e = -1;
                check("enc_data", int'(enc_data), e);
                stream_left--;
            end
            if (enc_start) begin
                check("start_latency", cyc - last_hs_cyc, 1);
                check("enc_data_at_start", int'(enc_data), 0);
                start_cyc   = cyc;
                start_seen  = 1'b1;
                stream_left = FL;
            end
            if (result_valid) begin
                res_seen = 1'b1;
                res_cyc  = cyc;
                res_fc   = int'(frame_cycles);
                res_src  = int'(frame_src);
                check("enc_data_at_report", int'(enc_data), 0);
            end
            if (err_timeout) begin
                tout_seen = 1'b1;
                tout_cyc  = cyc;
            end
        end
    end

    task automatic run_row(input row_t r);
        int n;
        res_seen  = 1'b0;
        tout_seen = 1'b0;
        rstn_low  = 0;
        rdy0      = 0;
        rdy1      = 0;
        esym_cnt  = 0;
        for (int k = 0; k < r.n0; k++) push_frame(0, r.bad, r.pat && k == 0);
        for (int k = 0; k < r.n1; k++) push_frame(1, r.bad, 1'b0);
        enc_delay = r.delay;
        n = 0;
        while (!res_seen && !tout_seen && n < LIMIT) begin
            @(posedge clk);
            n++;
        end
        check("frame_end_within_bound", int'(n < LIMIT), 1);
        if (r.exp_res) begin
            check("frame_src", res_src, r.exp_src);
            check("frame_cycles", res_fc, r.delay);
            check("result_time", res_cyc - start_cyc, (r.delay <= FL) ? FL + 1 : r.delay + 1);
            check("no_timeout", int'(tout_seen), 0);
        end else begin
            check("timeout_time", tout_cyc - start_cyc, TOUT);
            repeat (5) @(posedge clk);
            check("enc_rst_n_low_cycles", rstn_low, 2);
            check("no_result_on_timeout", int'(res_seen), 0);
        end
        check("other_ready_idle", (r.exp_src != 0) ? rdy0 : rdy1, 0);
        check("granted_ready_active", int'(((r.exp_src != 0) ? rdy1 : rdy0) >= FL), 1);
        check("err_symbol_count", esym_cnt, (r.bad >= 0) ? 1 : 0);
    endtask

    initial begin : main
        int n;
        //          n0 n1 bad delay res src pat
        rows[0] = '{2, 2, -1, 300, 1'b1, 0, 1'b1};
        rows[1] = '{0, 0, -1, 300, 1'b1, 1, 1'b0};
        rows[2] = '{0, 0, -1, 300, 1'b1, 0, 1'b0};
        rows[3] = '{0, 0, -1, 300, 1'b1, 1, 1'b0};
        rows[4] = '{1, 0,  3, 101, 1'b1, 0, 1'b0};
        rows[5] = '{1, 0, -1,   0, 1'b0, 0, 1'b0};
        rows[6] = '{1, 1, -1, 300, 1'b1, 1, 1'b0};
        rows[7] = '{0, 0, -1, 257, 1'b1, 0, 1'b0};
        rows[8] = '{0, 1, -1, 256, 1'b1, 1, 1'b0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_enc_rst_n", int'(enc_rst_n), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_src0_ready", int'(src0_ready), 0);
        check("rst_src1_ready", int'(src1_ready), 0);
        check("rst_enc_start", int'(enc_start), 0);
        check("rst_enc_data", int'(enc_data), 0);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_err_symbol", int'(err_symbol), 0);
        check("rst_err_timeout", int'(err_timeout), 0);
        check("rst_frame_cycles", int'(frame_cycles), 0);
        check("rst_frame_src", int'(frame_src), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_enc_rst_n", int'(enc_rst_n), 1);

        for (int i = 0; i < 9; i++) run_row(rows[i]);

        // Reset asserted while the encoder is being fed
        start_seen = 1'b0;
        push_frame(0, -1, 1'b0);
        enc_delay = 300;
        n = 0;
        while (!start_seen && n < 3 * FL) begin
            @(posedge clk);
            n++;
        end
        check("mid_rst_start_seen", int'(start_seen), 1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_enc_data", int'(enc_data), 0);
        check("mid_rst_enc_rst_n", int'(enc_rst_n), 0);
        check("mid_rst_src0_ready", int'(src0_ready), 0);
        check("mid_rst_enc_start", int'(enc_start), 0);
        check("mid_rst_result_valid", int'(result_valid), 0);
        check("mid_rst_frame_cycles", int'(frame_cycles), 0);
        check("mid_rst_frame_src", int'(frame_src), 0);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_enc_rst_n_held", int'(enc_rst_n), 0);
        end
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_release_enc_rst_n", int'(enc_rst_n), 1);
        check("mid_rst_release_busy", int'(busy), 0);

        // Arbiter priority must be back to src0 after reset
        run_row(row_t'{1, 1, -1, 300, 1'b1, 0, 1'b0});
        run_row(row_t'{0, 0, -1, 300, 1'b1, 1, 1'b0});

        check("never_both_ready", both_bad, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
